// File: rtl/true_dual_port_read_first_ram.sv
// Single-clock true dual-port RAM with read-first ports and selectable 1- or 2-cycle read latency.
// Out-of-range addresses (non power-of-two depth) drop writes and read back zero.
module true_dual_port_read_first_ram #(
  parameter int    RAM_WIDTH       = 18,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter string INIT_FILE       = "",
  localparam int   AW              = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [AW-1:0]        addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 wea,
  input  logic                 ena,
  input  logic                 regcea,
  output logic [RAM_WIDTH-1:0] douta,
  input  logic [AW-1:0]        addrb,
  input  logic [RAM_WIDTH-1:0] dinb,
  input  logic                 web,
  input  logic                 enb,
  input  logic                 regceb,
  output logic [RAM_WIDTH-1:0] doutb
);

  localparam bit            LOW_LAT = (RAM_PERFORMANCE == "LOW_LATENCY");
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(RAM_DEPTH);

  typedef logic [RAM_WIDTH-1:0] word_t;
  typedef word_t mem_t [RAM_DEPTH];

  function automatic mem_t load_mem();
    mem_t m;
    for (int i = 0; i < RAM_DEPTH; i++) m[i] = '0;
    return m;
  endfunction

  mem_t mem = load_mem();

  word_t ram_a_q, ram_a_d, ram_b_q, ram_b_d;
  word_t dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic  in_range_a, in_range_b;

  assign in_range_a = ({1'b0, addra} < DEPTH_L);
  assign in_range_b = ({1'b0, addrb} < DEPTH_L);

  // Port B is written last so it wins a same-address collision.
  always_ff @(posedge clk_in) begin
    if (ena && wea && in_range_a) mem[addra] <= dina;
    if (enb && web && in_range_b) mem[addrb] <= dinb;
  end

  always_comb begin
    ram_a_d  = ram_a_q;
    ram_b_d  = ram_b_q;
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    if (ena)    ram_a_d  = in_range_a ? mem[addra] : '0;
    if (enb)    ram_b_d  = in_range_b ? mem[addrb] : '0;
    if (regcea) dout_a_d = ram_a_q;
    if (regceb) dout_b_d = ram_b_q;
  end

  // Output stages clear on reset; memory contents are never touched by reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ram_a_q  <= '0;
      ram_b_q  <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      ram_a_q  <= ram_a_d;
      ram_b_q  <= ram_b_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end

  assign douta = LOW_LAT ? ram_a_q : dout_a_q;
  assign doutb = LOW_LAT ? ram_b_q : dout_b_q;

endmodule

// File: tb/tb_true_dual_port_read_first_ram.sv
// Bench for true_dual_port_read_first_ram: a 16-deep HIGH_PERFORMANCE and a 12-deep LOW_LATENCY
// instance share one stimulus stream; a scoreboard compares both against a reference model.
module tb_true_dual_port_read_first_ram;

  localparam int W  = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addra, addrb;
  logic [W-1:0]  dina, dinb;
  logic          wea, web, ena, enb, regcea, regceb;
  logic [W-1:0]  douta_hp, doutb_hp, douta_ll, doutb_ll;

  always #5 clk = ~clk;

  true_dual_port_read_first_ram #(
    .RAM_WIDTH(W), .RAM_DEPTH(16), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE("")
  ) dut_hp (
    .clk_in(clk), .rst_in(rst_n),
    .addra(addra), .dina(dina), .wea(wea), .ena(ena), .regcea(regcea), .douta(douta_hp),
    .addrb(addrb), .dinb(dinb), .web(web), .enb(enb), .regceb(regceb), .doutb(doutb_hp)
  );

  true_dual_port_read_first_ram #(
    .RAM_WIDTH(W), .RAM_DEPTH(12), .RAM_PERFORMANCE("LOW_LATENCY"), .INIT_FILE("")
  ) dut_ll (
    .clk_in(clk), .rst_in(rst_n),
    .addra(addra), .dina(dina), .wea(wea), .ena(ena), .regcea(regcea), .douta(douta_ll),
    .addrb(addrb), .dinb(dinb), .web(web), .enb(enb), .regceb(regceb), .doutb(doutb_ll)
  );

  // Reference model: instance 0 = 16 deep, 2-cycle; instance 1 = 12 deep, 1-cycle.
  logic [W-1:0] mm     [2][16];
  logic [W-1:0] ram_m  [2][2];
  logic [W-1:0] dout_m [2][2];

  typedef struct packed {
    logic [3:0][W-1:0] v;
    logic              he;
    logic [W-1:0]      hv;
    logic              le;
    logic [W-1:0]      lv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  task automatic model_edge();
    logic [AW-1:0] ad [2];
    logic [W-1:0]  dn [2];
    logic          e  [2];
    logic          w  [2];
    logic          rc [2];
    ad = '{addra, addrb};
    dn = '{dina, dinb};
    e  = '{ena, enb};
    w  = '{wea, web};
    rc = '{regcea, regceb};
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        for (int p = 0; p < 2; p++) begin
          if (rc[p]) dout_m[i][p] = ram_m[i][p];
          if (e[p])  ram_m[i][p]  = (int'(ad[p]) < dep(i)) ? mm[i][ad[p]] : '0;
        end
      end
      for (int p = 0; p < 2; p++)
        if (e[p] && w[p] && int'(ad[p]) < dep(i)) mm[i][ad[p]] = dn[p];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        ram_m[i][p]  = '0;
        dout_m[i][p] = '0;
      end
  endtask

  // One clock edge; the expectation for the outputs after it is queued for the monitor.
  task automatic cyc(input logic he = 1'b0, input logic [W-1:0] hv = '0,
                     input logic le = 1'b0, input logic [W-1:0] lv = '0,
                     input logic arst = 1'b0);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    if (arst) rst_n = 1'b0;
    if (!rst_n) model_clear();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        e.v[i*2+p] = (i == 0) ? dout_m[i][p] : ram_m[i][p];
    e.he = he; e.hv = hv; e.le = le; e.lv = lv;
    q.push_back(e);
  endtask

  task automatic pa(input logic e, input logic w, input logic rc,
                    input logic [AW-1:0] a, input logic [W-1:0] d);
    ena = e; wea = w; regcea = rc; addra = a; dina = d;
  endtask

  task automatic pb(input logic e, input logic w, input logic rc,
                    input logic [AW-1:0] a, input logic [W-1:0] d);
    enb = e; web = w; regceb = rc; addrb = a; dinb = d;
  endtask

  exp_t              me;
  logic [3:0][W-1:0] act;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me  = q.pop_front();
      act = {doutb_ll, douta_ll, doutb_hp, douta_hp};
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act[k] !== me.v[k]) begin
          errors++;
          $display("FAIL dout inst=%s port=%s: got %h expected %h at %0t",
                   (k < 2) ? "hp" : "ll", (k % 2 == 0) ? "A" : "B", act[k], me.v[k], $time);
        end
      end
      if (me.he) begin
        checks++;
        if (douta_hp !== me.hv) begin
          errors++;
          $display("FAIL douta_hp_literal: got %h expected %h at %0t", douta_hp, me.hv, $time);
        end
      end
      if (me.le) begin
        checks++;
        if (douta_ll !== me.lv) begin
          errors++;
          $display("FAIL douta_ll_literal: got %h expected %h at %0t", douta_ll, me.lv, $time);
        end
      end
    end
  end

  initial begin
    logic r;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 16; a++) mm[i][a] = '0;
    model_clear();
    pa(0, 0, 0, '0, '0);
    pb(0, 0, 0, '0, '0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    cyc(1, 12'h000);
    cyc(1, 12'h000);
    rst_n = 1'b1;

    // Initial contents are all zero
    for (int a = 0; a < 16; a++) begin
      pa(1, 0, 1, AW'(a), '0);
      cyc(1, 12'h000, 1, 12'h000);
    end

    // B writes, A reads two edges later on the pipelined instance
    pa(0, 0, 1, '0, '0); pb(1, 1, 1, 4'd5, 12'hABC); cyc();
    pb(0, 0, 1, '0, '0); pa(1, 0, 1, 4'd5, '0);      cyc(0, 0, 1, 12'hABC);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'hABC);

    // Async reset mid-cycle, with a write landing while reset is held
    cyc(1, 12'h000, 1, 12'h000, 1);
    pb(1, 1, 1, 4'd9, 12'h777);                      cyc(1, 12'h000);
    rst_n = 1'b1;
    pb(0, 0, 1, '0, '0); pa(1, 0, 1, 4'd5, '0);      cyc(0, 0, 1, 12'hABC);
    pa(1, 0, 1, 4'd9, '0);                           cyc(1, 12'hABC, 1, 12'h777);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'h777);

    // Read-first on the same port
    pb(1, 1, 1, 4'd3, 12'h111);                      cyc();
    pb(0, 0, 1, '0, '0); pa(1, 1, 1, 4'd3, 12'h222); cyc(0, 0, 1, 12'h111);
    pa(1, 0, 1, 4'd3, '0);                           cyc(1, 12'h111, 1, 12'h222);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'h222);

    // A reads while B writes the same address
    pb(1, 1, 1, 4'd7, 12'h333);                      cyc();
    pa(1, 0, 1, 4'd7, '0); pb(1, 1, 1, 4'd7, 12'h5A5); cyc(0, 0, 1, 12'h333);
    pb(0, 0, 1, '0, '0);                             cyc(1, 12'h333, 1, 12'h5A5);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'h5A5);

    // Both ports write the same address
    pa(1, 1, 1, 4'd2, 12'h0F0); pb(1, 1, 1, 4'd2, 12'hF0F); cyc();
    pb(0, 0, 1, '0, '0); pa(1, 0, 1, 4'd2, '0);      cyc(0, 0, 1, 12'hF0F);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'hF0F);

    // Disabled port ignores write enable
    pa(0, 1, 1, 4'd5, 12'h123);                      cyc(1, 12'hF0F, 1, 12'hF0F);
    pa(1, 0, 1, 4'd5, '0);                           cyc(0, 0, 1, 12'hABC);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'hABC);

    // Output register clock enable freezes the pipelined output
    pa(1, 0, 0, 4'd3, '0);                           cyc(1, 12'hABC, 1, 12'h222);
    pa(0, 0, 0, '0, '0);                             cyc(1, 12'hABC);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'h222);

    // Out-of-range address on the 12-deep instance
    pb(1, 1, 1, 4'd13, 12'hBAD);                     cyc();
    pb(0, 0, 1, '0, '0); pa(1, 0, 1, 4'd13, '0);     cyc(0, 0, 1, 12'h000);
    pa(0, 0, 1, '0, '0);                             cyc(1, 12'hBAD);
    for (int a = 0; a < 16; a++) begin
      pa(1, 0, 1, AW'(a), '0);
      pb(1, 0, 1, AW'(15 - a), '0);
      cyc();
    end

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      pa(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
         AW'($urandom_range(0, 15)), W'($urandom));
      pb(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
         AW'($urandom_range(0, 15)), W'($urandom));
      r = ($urandom_range(0, 39) == 0);
      cyc(0, 0, 0, 0, r);
      if (r) begin
        cyc();
        rst_n = 1'b1;
      end
    end

    pa(0, 0, 0, '0, '0);
    pb(0, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
